// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus command codes, decode bases and arbiter state encoding.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] M_NONE  = 2'b00;
  localparam logic [1:0] M_READ  = 2'b01;
  localparam logic [1:0] M_WRITE = 2'b10;

  localparam logic [8:0] SW_BASE  = 9'h140;
  localparam logic [8:0] LED_BASE = 9'h100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Only read and write are real bus operations; 00/11 are never granted.
  function automatic logic cmd_legal(input logic [1:0] c);
    return (c == M_READ) || (c == M_WRITE);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the master that did not win last time goes.
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       sel,
  output logic       any
);

  // Single requester wins outright; a tie flips away from last_grant.
  always_comb begin
    any = |eligible;
    sel = eligible[1];
    if (&eligible) sel = ~last_grant;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter/sequencer for the shared memory/I-O bus. One transaction
// at a time; bus fields are latched in IDLE so masters may change inputs freely
// once granted.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int RD_LAT = 0,
  parameter int AW     = 9,
  parameter int DW     = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic [1:0]    m0_cmd,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [1:0]    m1_cmd,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data,
  output logic          busy
);

  // WAIT counts down from RD_LAT-1 to 0; unused when RD_LAT is 0.
  localparam logic [2:0] CNT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [1:0]           mem_cmd_q, mem_cmd_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           rvalid_q, rvalid_d;
  logic [1:0][DW-1:0]   rdata_q, rdata_d;
  logic                 busy_q, busy_d;

  logic [1:0]           eligible;
  logic                 sel, any, sample;

  assign eligible = {m1_req & cmd_legal(m1_cmd), m0_req & cmd_legal(m0_cmd)};

  rr_arb2 u_arb (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .sel        (sel),
    .any        (any)
  );

  // Next-state and registered-output logic; sample captures read_data and
  // moves to RESP with the bus returned to idle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_cmd_d    = mem_cmd_q;
    mem_addr_d   = mem_addr_q;
    wdata_d      = wdata_q;
    gnt_d        = '0;
    rvalid_d     = '0;
    rdata_d      = rdata_q;
    sample       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        mem_cmd_d  = M_NONE;
        mem_addr_d = '0;
        wdata_d    = '0;
        if (any) begin
          mem_cmd_d    = sel ? m1_cmd   : m0_cmd;
          mem_addr_d   = sel ? m1_addr  : m0_addr;
          wdata_d      = sel ? m1_wdata : m0_wdata;
          owner_d      = sel;
          last_grant_d = sel;
          gnt_d[sel]   = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_cmd_q == M_WRITE) begin
          state_d    = S_IDLE;
          mem_cmd_d  = M_NONE;
          mem_addr_d = '0;
          wdata_d    = '0;
        end else if (RD_LAT == 0) begin
          sample = 1'b1;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) sample = 1'b1;
        else               cnt_d  = cnt_q - 3'd1;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (sample) begin
      rdata_d[owner_q]  = read_data;
      rvalid_d[owner_q] = 1'b1;
      mem_cmd_d         = M_NONE;
      mem_addr_d        = '0;
      wdata_d           = '0;
      state_d           = S_RESP;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mem_cmd_q    <= M_NONE;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_addr_q   <= mem_addr_d;
      wdata_q      <= wdata_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign m0_gnt     = gnt_q[0];
  assign m1_gnt     = gnt_q[1];
  assign m0_rvalid  = rvalid_q[0];
  assign m1_rvalid  = rvalid_q[1];
  assign m0_rdata   = rdata_q[0];
  assign m1_rdata   = rdata_q[1];
  assign mem_cmd    = mem_cmd_q;
  assign mem_addr   = mem_addr_q;
  assign write_data = wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: one instance with RD_LAT=0 (index 0) and one with
// RD_LAT=3 (index 1). Read responses are checked against a per-instance
// scoreboard queue filled when the read is requested.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  typedef struct {
    logic        m;
    logic [15:0] data;
  } sb_t;

  logic        clk, reset_n;
  logic        m0_req [2], m1_req [2];
  logic [1:0]  m0_cmd [2], m1_cmd [2];
  logic [8:0]  m0_addr [2], m1_addr [2];
  logic [15:0] m0_wdata [2], m1_wdata [2];
  logic        m0_gnt [2], m1_gnt [2], m0_rvalid [2], m1_rvalid [2];
  logic [15:0] m0_rdata [2], m1_rdata [2];
  logic [1:0]  mem_cmd [2];
  logic [8:0]  mem_addr [2];
  logic [15:0] write_data [2];
  logic        busy [2];
  logic [15:0] rd_data0, rd_data3, rd0_drv, rd3_drv;
  logic        rd0_model;

  int  n_chk, n_fail;
  sb_t sbq0[$], sbq1[$];

  // Small RAM image for instance 0 when rd0_model is set.
  function automatic logic [15:0] ram_val(input logic [8:0] a);
    return {7'h0, a} ^ 16'h5A00;
  endfunction

  assign rd_data0 = rd0_model ? ram_val(mem_addr[0]) : rd0_drv;
  assign rd_data3 = rd3_drv;

  mem_bus_arbiter #(.RD_LAT(0)) u_lat0 (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req[0]), .m0_cmd(m0_cmd[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
    .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]),
    .m1_req(m1_req[0]), .m1_cmd(m1_cmd[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
    .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]),
    .mem_cmd(mem_cmd[0]), .mem_addr(mem_addr[0]), .write_data(write_data[0]),
    .read_data(rd_data0), .busy(busy[0])
  );

  mem_bus_arbiter #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req[1]), .m0_cmd(m0_cmd[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
    .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]),
    .m1_req(m1_req[1]), .m1_cmd(m1_cmd[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
    .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]),
    .mem_cmd(mem_cmd[1]), .mem_addr(mem_addr[1]), .write_data(write_data[1]),
    .read_data(rd_data3), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    for (int i = 0; i < 2; i++) begin
      m0_req[i] = 1'b0; m0_cmd[i] = M_NONE; m0_addr[i] = '0; m0_wdata[i] = '0;
      m1_req[i] = 1'b0; m1_cmd[i] = M_NONE; m1_addr[i] = '0; m1_wdata[i] = '0;
    end
  endtask

  task automatic sb_mon(input int i);
    logic [1:0] rv;
    sb_t        e;
    rv = {m1_rvalid[i], m0_rvalid[i]};
    if (rv != 2'b00) begin
      if ((i == 0 ? sbq0.size() : sbq1.size()) == 0) begin
        chk($sformatf("sb%0d_unexp_rvalid", i), 32'(rv), 32'h0);
      end else begin
        e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
        chk($sformatf("sb%0d_rv_master", i), 32'(rv), e.m ? 32'h2 : 32'h1);
        chk($sformatf("sb%0d_rdata", i), 32'(e.m ? m1_rdata[i] : m0_rdata[i]), 32'(e.data));
      end
    end
  endtask

  // Scoreboard side: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    sb_mon(0);
    sb_mon(1);
  end

  initial begin
    int  ngr;
    logic exp_m, seen;
    n_chk = 0; n_fail = 0;
    clr_in();
    rd0_drv = '0; rd0_model = 1'b0; rd3_drv = 16'hDEAD;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state on both instances
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy",   32'(busy[i]), 32'h0);
      chk("rst_cmd",    32'(mem_cmd[i]), 32'h0);
      chk("rst_addr",   32'(mem_addr[i]), 32'h0);
      chk("rst_wdata",  32'(write_data[i]), 32'h0);
      chk("rst_gnt",    32'({m1_gnt[i], m0_gnt[i]}), 32'h0);
      chk("rst_rvalid", 32'({m1_rvalid[i], m0_rvalid[i]}), 32'h0);
      chk("rst_rdata",  32'({m1_rdata[i], m0_rdata[i]}), 32'h0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Single write from m0 to the LED register
    m0_req[0] = 1'b1; m0_cmd[0] = M_WRITE; m0_addr[0] = LED_BASE; m0_wdata[0] = 16'h00A5;
    @(negedge clk);
    chk("wr_gnt",   32'({m1_gnt[0], m0_gnt[0]}), 32'h1);
    chk("wr_cmd",   32'(mem_cmd[0]), 32'(M_WRITE));
    chk("wr_addr",  32'(mem_addr[0]), 32'(LED_BASE));
    chk("wr_wdata", 32'(write_data[0]), 32'h00A5);
    chk("wr_busy",  32'(busy[0]), 32'h1);
    m0_req[0] = 1'b0;
    @(negedge clk);
    chk("wr_cmd_off",  32'(mem_cmd[0]), 32'h0);
    chk("wr_addr_off", 32'(mem_addr[0]), 32'h0);
    chk("wr_gnt_off",  32'({m1_gnt[0], m0_gnt[0]}), 32'h0);
    chk("wr_busy_off", 32'(busy[0]), 32'h0);

    // Single read from m1, RD_LAT=0
    rd0_drv = 16'h1234;
    sbq0.push_back('{1'b1, 16'h1234});
    m1_req[0] = 1'b1; m1_cmd[0] = M_READ; m1_addr[0] = 9'h010;
    @(negedge clk);
    chk("rd_gnt",  32'({m1_gnt[0], m0_gnt[0]}), 32'h2);
    chk("rd_cmd",  32'(mem_cmd[0]), 32'(M_READ));
    chk("rd_addr", 32'(mem_addr[0]), 32'h010);
    m1_req[0] = 1'b0;
    @(negedge clk);
    chk("rd_rvalid",  32'({m1_rvalid[0], m0_rvalid[0]}), 32'h2);
    chk("rd_rdata",   32'(m1_rdata[0]), 32'h1234);
    chk("rd_m0rdata", 32'(m0_rdata[0]), 32'h0);
    chk("rd_resp_cmd",  32'(mem_cmd[0]), 32'h0);
    chk("rd_resp_addr", 32'(mem_addr[0]), 32'h0);
    chk("rd_resp_busy", 32'(busy[0]), 32'h1);
    @(negedge clk);
    chk("rd_done_busy", 32'(busy[0]), 32'h0);
    chk("rd_hold_rdata", 32'(m1_rdata[0]), 32'h1234);

    // Contention from reset: strict alternation starting with m0, one grant per 3 cycles
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd0_model = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sbq0.push_back('{1'b0, ram_val(9'h011)});
      sbq0.push_back('{1'b1, ram_val(9'h022)});
    end
    m0_req[0] = 1'b1; m0_cmd[0] = M_READ; m0_addr[0] = 9'h011;
    m1_req[0] = 1'b1; m1_cmd[0] = M_READ; m1_addr[0] = 9'h022;
    ngr = 0; exp_m = 1'b0;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      @(negedge clk);
      if (m0_gnt[0] | m1_gnt[0]) begin
        chk("cont_gnt_who", 32'({m1_gnt[0], m0_gnt[0]}), exp_m ? 32'h2 : 32'h1);
        chk("cont_gnt_cyc", 32'(c), 32'(3 * ngr));
        exp_m = ~exp_m;
        ngr++;
        if (ngr == 4) begin
          m0_req[0] = 1'b0;
          m1_req[0] = 1'b0;
        end
      end
    end
    chk("cont_ngrants", 32'(ngr), 32'h4);
    for (int c = 0; c < 20 && sbq0.size() > 0; c++) @(negedge clk);
    rd0_model = 1'b0;

    // RD_LAT=3 read of the switches; data only valid from the 4th bus cycle
    rd3_drv = 16'hDEAD;
    sbq1.push_back('{1'b0, 16'h0077});
    m0_req[1] = 1'b1; m0_cmd[1] = M_READ; m0_addr[1] = SW_BASE;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("lat3_cmd",    32'(mem_cmd[1]), 32'(M_READ));
      chk("lat3_addr",   32'(mem_addr[1]), 32'(SW_BASE));
      chk("lat3_rvalid", 32'({m1_rvalid[1], m0_rvalid[1]}), 32'h0);
      if (c == 1) begin
        chk("lat3_gnt", 32'({m1_gnt[1], m0_gnt[1]}), 32'h1);
        m0_req[1] = 1'b0;
      end
      if (c == 4) rd3_drv = 16'h0077;
    end
    @(negedge clk);
    chk("lat3_resp_rvalid", 32'({m1_rvalid[1], m0_rvalid[1]}), 32'h1);
    chk("lat3_resp_rdata",  32'(m0_rdata[1]), 32'h0077);
    chk("lat3_resp_cmd",    32'(mem_cmd[1]), 32'h0);
    chk("lat3_resp_busy",   32'(busy[1]), 32'h1);
    @(negedge clk);
    chk("lat3_done_busy", 32'(busy[1]), 32'h0);

    // Illegal commands are never granted
    m0_req[0] = 1'b1; m0_cmd[0] = 2'b11; m0_addr[0] = 9'h033;
    m1_req[0] = 1'b1; m1_cmd[0] = M_NONE; m1_addr[0] = 9'h044;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("ill_gnt",  32'({m1_gnt[0], m0_gnt[0]}), 32'h0);
      chk("ill_cmd",  32'(mem_cmd[0]), 32'h0);
      chk("ill_busy", 32'(busy[0]), 32'h0);
    end
    clr_in();

    // Reset during WAIT on the RD_LAT=3 instance
    rd3_drv = 16'h0ABC;
    m0_req[1] = 1'b1; m0_cmd[1] = M_READ; m0_addr[1] = 9'h055;
    @(negedge clk);
    chk("rw_gnt", 32'({m1_gnt[1], m0_gnt[1]}), 32'h1);
    m0_req[1] = 1'b0;
    @(negedge clk);
    chk("rw_wait_cmd",  32'(mem_cmd[1]), 32'(M_READ));
    chk("rw_wait_busy", 32'(busy[1]), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rw_rst_cmd",   32'(mem_cmd[1]), 32'h0);
    chk("rw_rst_addr",  32'(mem_addr[1]), 32'h0);
    chk("rw_rst_busy",  32'(busy[1]), 32'h0);
    chk("rw_rst_rdata", 32'(m0_rdata[1]), 32'h0);
    sbq1.push_back('{1'b0, 16'h0ABC});
    sbq1.push_back('{1'b1, 16'h0ABC});
    m0_req[1] = 1'b1; m0_cmd[1] = M_READ; m0_addr[1] = 9'h060;
    m1_req[1] = 1'b1; m1_cmd[1] = M_READ; m1_addr[1] = 9'h070;
    repeat (2) @(negedge clk);
    chk("rw_hold_busy", 32'(busy[1]), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rw_first_gnt", 32'({m1_gnt[1], m0_gnt[1]}), 32'h1);
    m0_req[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (m1_gnt[1]) begin
        seen = 1'b1;
        m1_req[1] = 1'b0;
      end
    end
    chk("rw_m1_gnt_seen", 32'(seen), 32'h1);
    for (int c = 0; c < 20 && (sbq0.size() + sbq1.size()) > 0; c++) @(negedge clk);
    @(negedge clk);
    chk("sb0_drained", 32'(sbq0.size()), 32'h0);
    chk("sb1_drained", 32'(sbq1.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
